// File: rtl/sparse_pkg.sv
// ----------------------------------------------------------------------------
// sparse_pkg
// Shared definitions for the sparse-operand producer path:
//   - fp16 field positions
//   - sparse_tok_t : one compressed token (column index, value, row tags)
//   - fp16_is_zero : zero test used to decide which elements are dropped
// ----------------------------------------------------------------------------
package sparse_pkg;

  localparam int FP16_EXP_MSB = 14;
  localparam int FP16_EXP_LSB = 10;
  localparam int FP16_MANT_W  = 10;

  // Token index storage is sized for the widest supported row (256 columns);
  // narrower encoders zero-extend into it and use only the low bits.
  localparam int TOK_IDX_W = 8;

  typedef struct packed {
    logic [TOK_IDX_W-1:0] index;
    logic [15:0]          value;
    logic                 last;
    logic                 zero_row;
  } sparse_tok_t;

  // Sign is ignored, so +0 and -0 both count as zero. NaN/Inf have a
  // non-zero exponent and are therefore always kept. With flush_denorm set,
  // any zero-exponent value (i.e. a subnormal) is dropped as well.
  function automatic logic fp16_is_zero(input logic [15:0] data,
                                        input logic        flush_denorm);
    logic exp_zero;
    logic mant_zero;
    exp_zero  = (data[FP16_EXP_MSB:FP16_EXP_LSB] == '0);
    mant_zero = (data[FP16_MANT_W-1:0] == '0);
    return exp_zero && (mant_zero || flush_denorm);
  endfunction

endpackage

// File: rtl/sparse_tok_fifo.sv
// ----------------------------------------------------------------------------
// sparse_tok_fifo
// Token FIFO that accepts up to two pushes and one pop per clock.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   push0_valid/push0_tok first token written this cycle
//   push1_valid/push1_tok second token (only meaningful with push0_valid)
//   pop                   remove head (ignored when empty)
//   head_tok              current head entry (undefined storage when empty)
//   count / free_cnt      occupied / free slots
// The caller must never push more tokens than free_cnt allows.
// ----------------------------------------------------------------------------
module sparse_tok_fifo
  import sparse_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push0_valid,
  input  sparse_tok_t              push0_tok,
  input  logic                     push1_valid,
  input  sparse_tok_t              push1_tok,
  input  logic                     pop,
  output sparse_tok_t              head_tok,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   free_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_plus1;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             pop_ok;
  logic [CNT_W-1:0] push_n;

  sparse_tok_t entries [DEPTH];

  // Depth is a power of two, so pointer arithmetic wraps for free.
  assign wr_ptr_plus1 = wr_ptr_reg + PTR_W'(1);
  assign pop_ok       = pop && (count_reg != '0);
  assign push_n       = CNT_W'(push0_valid) + CNT_W'(push0_valid && push1_valid);
  assign count_next   = count_reg + push_n - CNT_W'(pop_ok);

  // Storage: each slot decides for itself whether one of the two write ports
  // targets it this cycle. Data storage needs no reset; pointers gate it.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      sparse_tok_t entry_reg;
      always_ff @(posedge clk) begin
        if (push0_valid && (wr_ptr_reg == PTR_W'(gi))) begin
          entry_reg <= push0_tok;
        end else if (push0_valid && push1_valid && (wr_ptr_plus1 == PTR_W'(gi))) begin
          entry_reg <= push1_tok;
        end
      end
      assign entries[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(push_n);
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
    end
  end

  assign head_tok = entries[rd_ptr_reg];
  assign count    = count_reg;
  assign free_cnt = CNT_W'(DEPTH) - count_reg;

endmodule

// File: rtl/sparse_row_encoder.sv
// ----------------------------------------------------------------------------
// sparse_row_encoder
// Converts a dense fp16 row stream into (column, value) tokens, dropping
// zeros. The last nonzero of each row is tagged; an all-zero row yields a
// single marker token (index 0, value 0, last=1, zero_row=1).
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/in_last   dense element handshake
//   out_valid/out_ready/out_index/out_value/out_last/out_zero_row
//                                 token handshake, driven from FIFO head
//   row_nnz    nonzero count of the most recently completed row
//   row_done   one-cycle pulse per completed row
//   err_ovf    sticky: a row ran past 2**IDX_W elements
// ----------------------------------------------------------------------------
module sparse_row_encoder
  import sparse_pkg::*;
#(
  parameter int IDX_W        = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int FLUSH_DENORM = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [15:0]      out_value,
  output logic             out_last,
  output logic             out_zero_row,
  output logic [IDX_W:0]   row_nnz,
  output logic             row_done,
  output logic             err_ovf
);

  localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FREE_2  = CNT_W'(2);
  localparam logic [IDX_W-1:0] COL_MAX = '1;

  logic              ready_en_reg;
  logic [IDX_W-1:0]  col_reg;
  logic [IDX_W:0]    nnz_cnt_reg;
  logic [IDX_W:0]    row_nnz_reg;
  logic              pend_valid_reg;
  logic [IDX_W-1:0]  pend_idx_reg;
  logic [15:0]       pend_val_reg;
  logic              row_done_reg;
  logic              err_ovf_reg;

  logic              accept;
  logic              is_zero;
  logic              col_wrap;
  logic              row_end;
  logic              push0_valid;
  logic              push1_valid;
  sparse_tok_t       push0_tok;
  sparse_tok_t       push1_tok;
  sparse_tok_t       pend_tok;
  sparse_tok_t       new_tok;
  sparse_tok_t       marker_tok;
  sparse_tok_t       head_tok;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  fifo_free;
  logic              unused_idx_bits;

  // Two free slots are required so that a row-ending nonzero can flush the
  // held-back token and its own token in the same cycle.
  assign in_ready = ready_en_reg && (fifo_free >= FREE_2);
  assign accept   = in_valid && in_ready;
  assign is_zero  = fp16_is_zero(in_data, FLUSH_DENORM != 0);
  // A row that reaches the last addressable column is forced to end there.
  assign col_wrap = (col_reg == COL_MAX);
  assign row_end  = in_last || col_wrap;

  always_comb begin
    pend_tok          = '0;
    pend_tok.index    = TOK_IDX_W'(pend_idx_reg);
    pend_tok.value    = pend_val_reg;
    new_tok           = '0;
    new_tok.index     = TOK_IDX_W'(col_reg);
    new_tok.value     = in_data;
    new_tok.last      = 1'b1;
    marker_tok        = '0;
    marker_tok.last     = 1'b1;
    marker_tok.zero_row = 1'b1;

    push0_valid = 1'b0;
    push1_valid = 1'b0;
    push0_tok   = pend_tok;
    push1_tok   = new_tok;

    if (accept) begin
      if (!is_zero) begin
        if (!row_end) begin
          // Previous held nonzero is now known not to be last.
          push0_valid = pend_valid_reg;
        end else if (pend_valid_reg) begin
          push0_valid = 1'b1;
          push1_valid = 1'b1;
        end else begin
          push0_valid = 1'b1;
          push0_tok   = new_tok;
        end
      end else if (row_end) begin
        push0_valid = 1'b1;
        if (pend_valid_reg) begin
          push0_tok.last = 1'b1;
        end else begin
          push0_tok = marker_tok;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_en_reg   <= 1'b0;
      col_reg        <= '0;
      nnz_cnt_reg    <= '0;
      row_nnz_reg    <= '0;
      pend_valid_reg <= 1'b0;
      pend_idx_reg   <= '0;
      pend_val_reg   <= '0;
      row_done_reg   <= 1'b0;
      err_ovf_reg    <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      row_done_reg <= 1'b0;
      if (accept) begin
        if (row_end) begin
          col_reg        <= '0;
          nnz_cnt_reg    <= '0;
          row_nnz_reg    <= nnz_cnt_reg + (IDX_W+1)'(!is_zero);
          row_done_reg   <= 1'b1;
          pend_valid_reg <= 1'b0;
        end else begin
          col_reg <= col_reg + IDX_W'(1);
          if (!is_zero) begin
            nnz_cnt_reg    <= nnz_cnt_reg + (IDX_W+1)'(1);
            pend_valid_reg <= 1'b1;
            pend_idx_reg   <= col_reg;
            pend_val_reg   <= in_data;
          end
        end
        if (col_wrap && !in_last) begin
          err_ovf_reg <= 1'b1;
        end
      end
    end
  end

  sparse_tok_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push0_valid (push0_valid),
    .push0_tok   (push0_tok),
    .push1_valid (push1_valid),
    .push1_tok   (push1_tok),
    .pop         (out_ready),
    .head_tok    (head_tok),
    .count       (fifo_count),
    .free_cnt    (fifo_free)
  );

  // Head fields are forced to zero while empty so idle outputs read as 0.
  assign out_valid    = (fifo_count != '0);
  assign out_index    = out_valid ? head_tok.index[IDX_W-1:0] : '0;
  assign out_value    = out_valid ? head_tok.value : '0;
  assign out_last     = out_valid && head_tok.last;
  assign out_zero_row = out_valid && head_tok.zero_row;

  assign row_nnz  = row_nnz_reg;
  assign row_done = row_done_reg;
  assign err_ovf  = err_ovf_reg;

  // Upper index bits are always zero-extension; consumed here only.
  assign unused_idx_bits = ^head_tok.index;

endmodule
